// File: rtl/display_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one shared BCD decoder, DIGITS common-anode positions,
// double-buffered value committed at frame boundaries, optional leading-zero blanking.
module display_scan_ctrl #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] value,
  input  logic                blank_lz,
  input  logic [6:0]          S,
  output logic [3:0]          BCD,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   an,
  output logic                pending,
  output logic                frame_done
);

  localparam int TW = $clog2(REFRESH_DIV);
  localparam int DW = $clog2(DIGITS);
  localparam logic [TW-1:0] TICK_LAST  = TW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);

  logic [TW-1:0]       tick;
  logic [DW-1:0]       digit;
  logic [4*DIGITS-1:0] active;
  logic [4*DIGITS-1:0] pend_buf;
  logic                pend_flag;
  logic                digit_tick;
  logic                boundary;
  logic [DIGITS-1:0]   zero_from;
  logic                blank;

  assign digit_tick = (tick == TICK_LAST);
  assign boundary   = digit_tick && (digit == DIGIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick      <= '0;
      digit     <= '0;
      active    <= '0;
      pend_buf  <= '0;
      pend_flag <= 1'b0;
    end else begin
      if (digit_tick) begin
        tick  <= '0;
        digit <= (digit == DIGIT_LAST) ? '0 : digit + 1'b1;
      end else begin
        tick <= tick + 1'b1;
      end

      // A load landing on the boundary bypasses the pending buffer so it shows next cycle.
      if (load && boundary) begin
        active    <= value;
        pend_flag <= 1'b0;
      end else if (load) begin
        pend_buf  <= value;
        pend_flag <= 1'b1;
      end else if (boundary && pend_flag) begin
        active    <= pend_buf;
        pend_flag <= 1'b0;
      end
    end
  end

  // zero_from[i] is set when every nibble from position i upward is zero.
  always_comb begin
    zero_from = '0;
    zero_from[DIGITS-1] = (active[4*(DIGITS-1) +: 4] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] && (active[4*i +: 4] == 4'd0);
    end
  end

  assign blank      = blank_lz && (digit != '0) && zero_from[digit];
  assign BCD        = active[4*digit +: 4];
  assign seg        = blank ? 7'd0 : S;
  assign an         = DIGITS'(1) << digit;
  assign pending    = pend_flag;
  assign frame_done = boundary;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl (DIGITS=4, REFRESH_DIV=4): directed scenarios with literal
// expectations, then randomized traffic against a cycle-count based reference model.
module tb_display_scan_ctrl;

  localparam int DIGITS = 4;
  localparam int RD     = 4;
  localparam int FRAME  = DIGITS * RD;

  logic        clk = 1'b0;
  logic        rst, load, blank_lz;
  logic [15:0] value;
  logic [6:0]  S;
  logic [3:0]  BCD;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        pending, frame_done;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: position in frame is derived purely from cycles since reset.
  int          m_cyc = 0;
  logic [15:0] m_act, m_pv;
  logic        m_pnd;
  bit          m_valid = 1'b0;

  logic [3:0] l_an, l_bcd;
  logic [6:0] l_seg;
  logic       l_pend, l_fd;

  always #5 clk = ~clk;

  display_scan_ctrl #(.DIGITS(DIGITS), .REFRESH_DIV(RD)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .blank_lz(blank_lz), .S(S),
    .BCD(BCD), .seg(seg), .an(an), .pending(pending), .frame_done(frame_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, compare against the model, then advance the model at the edge.
  task automatic cycle(input logic r, input logic l, input logic [15:0] v,
                       input logic b, input logic [6:0] s);
    int   d;
    logic blanked;
    bit   bnd;
    rst = r; load = l; value = v; blank_lz = b; S = s;
    #1;
    l_an = an; l_bcd = BCD; l_seg = seg; l_pend = pending; l_fd = frame_done;
    if (m_valid) begin
      d = (m_cyc / RD) % DIGITS;
      blanked = b && (d > 0) && ((m_act >> (4 * d)) == 16'h0);
      chk("an", an, 32'(1 << d));
      chk("bcd", BCD, (m_act >> (4 * d)) & 16'hF);
      chk("seg", seg, blanked ? 7'h0 : s);
      chk("pending", pending, m_pnd);
      chk("frame_done", frame_done, (m_cyc % FRAME) == FRAME - 1);
    end
    @(posedge clk);
    bnd = m_valid && ((m_cyc % FRAME) == FRAME - 1);
    if (r) begin
      m_cyc = 0; m_act = '0; m_pv = '0; m_pnd = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (l && bnd) begin
        m_act = v; m_pnd = 1'b0;
      end else if (l) begin
        m_pv = v; m_pnd = 1'b1;
      end else if (bnd && m_pnd) begin
        m_act = m_pv; m_pnd = 1'b0;
      end
      m_cyc++;
    end
    @(negedge clk);
  endtask

  initial begin
    logic        r, l, b;
    logic [15:0] v;
    logic [6:0]  s;
    rst = 1'b1; load = 1'b0; value = '0; blank_lz = 1'b0; S = '0;
    @(negedge clk);
    cycle(1'b1, 1'b0, 16'h0, 1'b0, 7'h3C);
    cycle(1'b1, 1'b0, 16'h0, 1'b0, 7'h3C);
    chk("reset_an", l_an, 4'b0001);
    chk("reset_bcd", l_bcd, 4'h0);
    chk("reset_seg", l_seg, 7'h3C);
    chk("reset_pending", l_pend, 1'b0);
    chk("reset_frame_done", l_fd, 1'b0);

    // k counts cycles since reset release; the reset at k=105 restarts the cadence at k=106.
    for (int k = 0; k < 128; k++) begin
      r = 1'b0; l = 1'b0; v = 16'h0; s = 7'h55;
      b = ((k >= 32 && k < 48) || (k >= 80 && k < 96));
      case (k)
        5:   begin l = 1'b1; v = 16'h1234; end
        31:  begin l = 1'b1; v = 16'h0070; end
        45:  begin l = 1'b1; v = 16'h1111; end
        47:  begin l = 1'b1; v = 16'h5678; end
        50:  begin l = 1'b1; v = 16'h1111; end
        55:  begin l = 1'b1; v = 16'h2222; end
        79:  begin l = 1'b1; v = 16'h0000; end
        97:  begin l = 1'b1; v = 16'h9999; end
        105: r = 1'b1;
        default: ;
      endcase
      cycle(r, l, v, b, s);
      case (k)
        0:   chk("idle_an_d0", l_an, 4'b0001);
        4:   chk("idle_an_d1", l_an, 4'b0010);
        6:   chk("load_pending_rise", l_pend, 1'b1);
        14:  chk("idle_no_fd", l_fd, 1'b0);
        15:  begin
               chk("first_fd", l_fd, 1'b1);
               chk("first_fd_an", l_an, 4'b1000);
               chk("old_bcd_kept", l_bcd, 4'h0);
             end
        16:  begin chk("new_d0", l_bcd, 4'h4); chk("pending_fall", l_pend, 1'b0); end
        20:  chk("new_d1", l_bcd, 4'h3);
        24:  chk("new_d2", l_bcd, 4'h2);
        28:  chk("new_d3", l_bcd, 4'h1);
        32:  begin chk("lz_d0_seg", l_seg, 7'h55); chk("lz_d0_bcd", l_bcd, 4'h0); end
        36:  begin chk("lz_d1_seg", l_seg, 7'h55); chk("lz_d1_bcd", l_bcd, 4'h7); end
        40:  chk("lz_d2_blank", l_seg, 7'h00);
        44:  chk("lz_d3_blank", l_seg, 7'h00);
        46:  chk("older_pending", l_pend, 1'b1);
        48:  begin chk("bnd_load_d0", l_bcd, 4'h8); chk("bnd_load_pend", l_pend, 1'b0); end
        52:  chk("bnd_load_d1", l_bcd, 4'h7);
        64:  chk("two_loads_d0", l_bcd, 4'h2);
        68:  chk("two_loads_d1", l_bcd, 4'h2);
        72:  chk("two_loads_d2", l_bcd, 4'h2);
        76:  chk("two_loads_d3", l_bcd, 4'h2);
        80:  chk("zero_d0_shown", l_seg, 7'h55);
        84:  chk("zero_d1_blank", l_seg, 7'h00);
        88:  chk("zero_d2_blank", l_seg, 7'h00);
        92:  chk("zero_d3_blank", l_seg, 7'h00);
        98:  chk("pre_rst_pending", l_pend, 1'b1);
        104: chk("pre_rst_digit2", l_an, 4'b0100);
        106: begin
               chk("post_rst_an", l_an, 4'b0001);
               chk("post_rst_bcd", l_bcd, 4'h0);
               chk("post_rst_pending", l_pend, 1'b0);
             end
        111: chk("post_rst_no_old_fd", l_fd, 1'b0);
        121: chk("post_rst_fd", l_fd, 1'b1);
        default: ;
      endcase
    end

    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      l = ($urandom_range(0, 5) == 0);
      v = 16'($urandom) >> (4 * $urandom_range(0, 4));
      b = 1'($urandom);
      s = 7'($urandom);
      cycle(r, l, v, b, s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexing scan controller that shares the single 4-bit-BCD-to-7-segment `display` decoder among DIGITS common-anode positions. It holds a double-buffered multi-digit value, steps one digit per refresh interval, and drives the decoder's `BCD` input and the one-hot digit enables. It gates the decoder's `S` output for leading-zero blanking. Updates are committed only at frame boundaries so that no scan frame shows a mix of old and new digits.

## Interface
- DIGITS, 4: number of multiplexed digit positions (2..8); digit 0 = least significant.
- REFRESH_DIV, 50000: clock cycles each digit stays selected (≥2).
- clk  in  1  system clock; everything is rising-edge.
- rst  in  1  synchronous, active-high reset.
- load  in  1  one-cycle request to capture `value`.
- value  in  4*DIGITS  nibble i = BCD for digit i; codes 10–15 are passed to the decoder unchanged.
- blank_lz  in  1  1 = blank leading zeros (sampled every cycle).
- S  in  7  segment pattern returned by the shared `display` decoder for the current `BCD`.
- BCD  out  4  nibble of the selected digit, to the decoder input.
- seg  out  7  segment drive, active-high; equals `S`, or 7'b0 when the current digit is blanked.
- an  out  DIGITS  one-hot digit enable, active-high.
- pending  out  1  a loaded value is waiting for the next frame boundary.
- frame_done  out  1  one-cycle pulse when a full scan completes.

## Operation
- Registers:
  - tick counter (0..REFRESH_DIV-1)
  - digit index (0..DIGITS-1)
  - active buffer and pending buffer (4*DIGITS each)
  - pending flag
- Every cycle the tick counter increments. When tick = REFRESH_DIV-1 ("digit tick"), the tick counter wraps to 0 and the digit index increments, wrapping DIGITS-1 → 0.
- Frame boundary: a digit tick while digit = DIGITS-1. On this cycle:
  - frame_done = 1.
  - If the pending flag is set, pending buffer → active buffer and the flag clears.
- Load:
  - `load` writes `value` to the pending buffer and sets the flag.
  - A load while already pending overwrites the pending value; the latest load wins.
  - A load on a frame-boundary cycle writes `value` directly to the active buffer and clears the flag. Any older pending value is discarded.
- BCD = active[4*digit +: 4].
- an = 1 << digit.
- Blanking: digit i>0 is blanked iff blank_lz=1 and every active nibble j≥i equals 0. Digit 0 is never blanked, so an all-zero value shows "0".
- An, BCD and seg depend combinationally on registers and blank_lz/S only. There is no combinational path from `load`/`value`.

## Timing
- Reset values:
  - tick=0, digit=0, active=0, pending buffer=0, pending=0.
  - an=1 (digit 0 selected), BCD=0, frame_done=0.
  - seg=S, since digit 0 is never blanked.
- Each digit stays selected for exactly REFRESH_DIV cycles. A frame is DIGITS*REFRESH_DIV cycles.
- frame_done asserts during the cycle with tick=REFRESH_DIV-1 and digit=DIGITS-1. The next cycle shows digit 0 from the updated active buffer.
- `pending` rises the cycle after a non-boundary `load`. It falls the cycle after the frame boundary.
- Load-to-display latency: at most DIGITS*REFRESH_DIV cycles and at least 1 cycle. A boundary-coincident load is visible on digit 0 the next cycle.
- Reset mid-scan: all state returns to reset values on the next edge. Pending data is lost and no frame_done is generated.
- `S` is assumed valid in the same cycle as `BCD`, because the decoder is combinational.

## Test plan
All scenarios use DIGITS=4 and REFRESH_DIV=4.
- Reset then idle:
  - an sequence is 0001,0010,0100,1000, each held 4 cycles.
  - frame_done pulses every 16 cycles, first at cycle 15 after reset release.
  - BCD=0 throughout.
- Load value=16'h1234 at cycle 5 (mid-frame):
  - pending=1 from cycle 6 until the boundary.
  - BCD stays 0 through cycle 15.
  - BCD = 4,3,2,1 for digits 0..3 in the next frame.
- Leading-zero blanking, blank_lz=1, value=16'h0070:
  - seg=0 on digits 3 and 2.
  - seg=S on digit 1 (BCD=7) and digit 0 (BCD=0).
  - With value=0, only digit 0 is unblanked.
- Load exactly on the frame_done cycle with 16'h5678:
  - pending stays 0.
  - Digit 0 shows BCD=8 on the following cycle.
  - A simultaneous older pending value is discarded.
- Two loads in one frame (16'h1111 then 16'h2222): the next frame shows 2 on all digits.
- Assert rst while digit=2 and pending=1:
  - Next cycle an=0001, BCD=0, pending=0.
  - The frame_done cadence restarts from cycle 15.
